// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, stall, flush and a saturating stall counter.
// Define PIPE_SKID_EN to use a 2-entry skid buffer so in_ready has no combinational path from out_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 32,
  parameter int N_DATA = 3,
  parameter int ADDR_W = 5,
  parameter int N_ADDR = 3,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic [N_DATA*DATA_W-1:0] data_in,
  input  logic [N_ADDR*ADDR_W-1:0] addr_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic [N_DATA*DATA_W-1:0] data_out,
  output logic [N_ADDR*ADDR_W-1:0] addr_out,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic in_fire_s;
  logic main_free_s;

  assign in_fire_s   = in_valid && in_ready;
  assign main_free_s = !out_valid || out_ready;

`ifdef PIPE_SKID_EN
  logic                     skid_valid_r;
  logic [CTRL_W-1:0]        skid_ctrl_r;
  logic [N_DATA*DATA_W-1:0] skid_data_r;
  logic [N_ADDR*ADDR_W-1:0] skid_addr_r;

  assign in_ready = !rst && !stall && !skid_valid_r;

  // Main/skid entry update; skid only fills while main is blocked, so main is never empty with skid full
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      ctrl_out     <= '0;
      data_out     <= '0;
      addr_out     <= '0;
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= '0;
      skid_data_r  <= '0;
      skid_addr_r  <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      ctrl_out     <= '0;
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= '0;
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        out_valid    <= 1'b1;
        ctrl_out     <= skid_ctrl_r;
        data_out     <= skid_data_r;
        addr_out     <= skid_addr_r;
        skid_valid_r <= 1'b0;
        skid_ctrl_r  <= '0;
      end else if (in_fire_s) begin
        out_valid <= 1'b1;
        ctrl_out  <= ctrl_in;
        data_out  <= data_in;
        addr_out  <= addr_in;
      end else begin
        out_valid <= 1'b0;
        ctrl_out  <= '0;
      end
    end else if (in_fire_s) begin
      skid_valid_r <= 1'b1;
      skid_ctrl_r  <= ctrl_in;
      skid_data_r  <= data_in;
      skid_addr_r  <= addr_in;
    end
  end
`else
  assign in_ready = !rst && !stall && main_free_s;

  // Single-entry update: flush beats capture, a drain with no new input leaves a zero-control bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_out  <= '0;
      data_out  <= '0;
      addr_out  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ctrl_out  <= '0;
    end else if (in_fire_s) begin
      out_valid <= 1'b1;
      ctrl_out  <= ctrl_in;
      data_out  <= data_in;
      addr_out  <= addr_in;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      ctrl_out  <= '0;
    end
  end
`endif

  // Saturating count of cycles where upstream offered data but the stage refused it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule
